lcd_scanout: RTL and testbench

//  Pixel-clock display scan-out stage fed by the framebuffer arbiter's read-FIFO stream (aso_out0_*).

---
 rtl/lcd_scanout.sv | 163 ++++++++++++++++
 tb/tb_lcd_scanout.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_scanout.sv
// Pixel-clock LCD scan-out: raster timing generator plus RGB565 stream pop and RGB888 expansion.
// Every panel output is registered one clock after the counter position that produced it.
module lcd_scanout #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 48,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 13,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 32,
    parameter bit          SYNC_POL = 1'b0,
    parameter logic [23:0] UF_COLOR = 24'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        asi_in0_valid,
    input  logic [15:0] asi_in0_data,
    output logic        asi_in0_ready,
    output logic [23:0] lcd_rgb,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic        lcd_de,
    output logic        frame_done,
    output logic        underflow,
    output logic [15:0] underflow_count,
    input  logic        clr_underflow
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // One spare bit so the sync end bound still fits when the back porch is zero.
    localparam int unsigned HW = $clog2(H_TOTAL + 1);
    localparam int unsigned VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_HS0  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_HS1  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_VS0  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_VS1  = VW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          de_q, de_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          fd_q, fd_d;
    logic          uf_q, uf_d;
    logic [15:0]   ufc_q, ufc_d;

    logic running, frame_end, active, hs_act, vs_act, uf_now;
    logic [23:0] px888;

    assign running   = (state_q != S_OFF);
    assign frame_end = running && (h_q == H_LAST) && (v_q == V_LAST);
    assign active    = running && (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_act    = running && (h_q >= H_HS0) && (h_q < H_HS1);
    assign vs_act    = running && (v_q >= V_VS0) && (v_q < V_VS1);
    assign uf_now    = active && !asi_in0_valid;

    // Ready depends only on registered position, never on valid.
    assign asi_in0_ready = active;

    // Bit replication keeps full-scale 5/6-bit values mapping to 8'hFF.
    assign px888 = {asi_in0_data[15:11], asi_in0_data[15:13],
                    asi_in0_data[10:5],  asi_in0_data[10:9],
                    asi_in0_data[4:0],   asi_in0_data[4:2]};

    // Mode FSM and raster counters; STOP keeps scanning so a frame is never cut short.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        case (state_q)
            S_OFF:   if (enable) state_d = S_RUN;
            S_RUN:   if (!enable) state_d = S_STOP;
            S_STOP:  if (frame_end) state_d = enable ? S_RUN : S_OFF;
            default: state_d = S_OFF;
        endcase
        if (running) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_comb begin
        de_d = active;
        hs_d = hs_act ? SYNC_POL : ~SYNC_POL;
        vs_d = vs_act ? SYNC_POL : ~SYNC_POL;
        fd_d = frame_end;
        if (!active) begin
            rgb_d = '0;
        end else if (asi_in0_valid) begin
            rgb_d = px888;
        end else begin
            rgb_d = UF_COLOR;
        end
    end

    // A clear in the same clock as a fresh underflow leaves exactly that one recorded.
    always_comb begin
        uf_d  = uf_q;
        ufc_d = ufc_q;
        if (clr_underflow) begin
            uf_d  = uf_now;
            ufc_d = uf_now ? 16'd1 : 16'd0;
        end else if (uf_now) begin
            uf_d = 1'b1;
            if (ufc_q != 16'hFFFF) ufc_d = ufc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OFF;
            h_q     <= '0;
            v_q     <= '0;
            rgb_q   <= '0;
            de_q    <= 1'b0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            fd_q    <= 1'b0;
            uf_q    <= 1'b0;
            ufc_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            rgb_q   <= rgb_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fd_q    <= fd_d;
            uf_q    <= uf_d;
            ufc_q   <= ufc_d;
        end
    end

    assign lcd_rgb         = rgb_q;
    assign lcd_de          = de_q;
    assign lcd_hsync       = hs_q;
    assign lcd_vsync       = vs_q;
    assign frame_done      = fd_q;
    assign underflow       = uf_q;
    assign underflow_count = ufc_q;

endmodule

// File: tb/tb_lcd_scanout.sv
// Scoreboarded bench for lcd_scanout on a shrunken raster; the reference model walks a
// linear pixel index per frame and derives every expected panel value from it.
module tb_lcd_scanout;

    localparam int HA = 48, HFP = 1, HS = 2, HBP = 1;
    localparam int VA = 40, VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int F  = HT * VT;
    localparam bit POL = 1'b0;
    localparam logic [23:0] UFC = 24'hA55AC3;

    logic        clk, rst_n, enable, asi_in0_valid, asi_in0_ready, clr_underflow;
    logic [15:0] asi_in0_data, underflow_count;
    logic [23:0] lcd_rgb;
    logic        lcd_hsync, lcd_vsync, lcd_de, frame_done, underflow;

    lcd_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(POL), .UF_COLOR(UFC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .asi_in0_valid(asi_in0_valid), .asi_in0_data(asi_in0_data),
        .asi_in0_ready(asi_in0_ready), .lcd_rgb(lcd_rgb),
        .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
        .frame_done(frame_done), .underflow(underflow),
        .underflow_count(underflow_count), .clr_underflow(clr_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        de, hs, vs, fd, uf;
        logic [15:0] ufc;
        logic [23:0] rgb;
    } exp_t;

    exp_t sb[$];
    int checks = 0, errors = 0;
    int pops = 0, de_seen = 0, fd_seen = 0, hs_seen = 0, vs_seen = 0;

    // Reference model state: scanning flag, stop pending, pixel index within the frame.
    bit m_on = 0, m_stop = 0, m_uf = 0;
    int m_pos = 0, m_ufc = 0, m_uf_raw = 0;

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] expand(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
    endfunction

    // One pixel clock: drive inputs, check ready, queue the registered outputs, advance model.
    task automatic step(input logic en, input logic val, input logic clr, input logic [15:0] d);
        int h, v;
        logic act, hsa, vsa, ufn;
        exp_t e;
        @(negedge clk);
        enable = en; asi_in0_valid = val; asi_in0_data = d; clr_underflow = clr;
        #1;
        h   = m_pos % HT;
        v   = m_pos / HT;
        act = m_on && (h < HA) && (v < VA);
        hsa = m_on && (h >= HA + HFP) && (h < HA + HFP + HS);
        vsa = m_on && (v >= VA + VFP) && (v < VA + VFP + VS);
        ufn = act && !val;
        cmp("ready", asi_in0_ready, act);
        if (asi_in0_ready && val) pops++;
        if (clr) begin
            m_uf  = ufn;
            m_ufc = ufn ? 1 : 0;
        end else if (ufn) begin
            m_uf = 1;
            if (m_ufc < 65535) m_ufc++;
        end
        if (ufn) m_uf_raw++;
        e.de  = act;
        e.hs  = hsa ? POL : !POL;
        e.vs  = vsa ? POL : !POL;
        e.fd  = m_on && (m_pos == F - 1);
        e.uf  = m_uf;
        e.ufc = 16'(m_ufc);
        e.rgb = !act ? 24'h0 : (val ? expand(d) : UFC);
        sb.push_back(e);
        if (!m_on) begin
            if (en) begin m_on = 1; m_stop = 0; m_pos = 0; end
        end else begin
            if (m_pos == F - 1 && m_stop) begin
                m_on = en; m_stop = 0;
            end else if (!m_stop && !en) begin
                m_stop = 1;
            end
            m_pos = (m_pos + 1) % F;
        end
    endtask

    task automatic rstep(input int en_pct, input int val_pct);
        step(($urandom_range(0, 99) < en_pct), ($urandom_range(0, 99) < val_pct),
             ($urandom_range(0, 49) == 0), 16'($urandom()));
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; enable = 0; asi_in0_valid = 0; clr_underflow = 0;
        #1;
        cmp("reset_outs", {lcd_rgb, lcd_de, lcd_hsync, lcd_vsync, frame_done, underflow, underflow_count},
            {24'h0, 1'b0, !POL, !POL, 1'b0, 1'b0, 16'h0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp("reset_ready", {asi_in0_ready, lcd_de, underflow_count}, 18'h0);
        end
        rst_n = 1;
        m_on = 0; m_stop = 0; m_pos = 0; m_uf = 0; m_ufc = 0;
    endtask

    // Monitor: every clock the DUT presents one registered output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (lcd_de) de_seen++;
            if (frame_done) fd_seen++;
            if (lcd_hsync == POL) hs_seen++;
            if (lcd_vsync == POL) vs_seen++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("scoreboard",
                    {lcd_de, lcd_hsync, lcd_vsync, frame_done, underflow, underflow_count, lcd_rgb},
                    {e.de, e.hs, e.vs, e.fd, e.uf, e.ufc, e.rgb});
            end
        end
    end

    initial begin
        logic [15:0] words [5];
        logic [23:0] cols  [5];
        int de0, fd0, hs0, vs0, pop0;
        words = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF, 16'h0000};
        cols  = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF, 24'h000000};
        rst_n = 0; enable = 0; asi_in0_valid = 0; asi_in0_data = '0; clr_underflow = 0;
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 1, 0, 16'($urandom()));
        step(1, 1, 0, 16'h1234);
        for (int i = 0; i < 200; i++) rstep(100, 85);

        // T1: reset mid-line, stay idle while disabled.
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 1, 0, 16'($urandom()));
        step(1, 1, 0, 16'h0);

        // T2 + T3: colour words lead two full frames with valid held high.
        de0 = de_seen; fd0 = fd_seen; hs0 = hs_seen; vs0 = vs_seen; pop0 = pops;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, words[i]);
            after_edge();
            cmp("t2_colour", {lcd_de, lcd_rgb}, {1'b1, cols[i]});
        end
        for (int i = 5; i < 2 * F; i++) step(1, 1, 0, 16'($urandom()));
        after_edge();
        cmp("t3_de_clocks", de_seen - de0, 2 * HA * VA);
        cmp("t3_pops", pops - pop0, 2 * HA * VA);
        cmp("t3_frame_done", fd_seen - fd0, 2);
        cmp("t3_hsync_clocks", hs_seen - hs0, 2 * VT * HS);
        cmp("t3_vsync_clocks", vs_seen - vs0, 2 * VS * HT);

        // T4: five starved pixels, then clear, then clear colliding with a new underflow.
        step(1, 1, 1, 16'($urandom()));
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 16'($urandom()));
            after_edge();
            cmp("t4_uf_colour", lcd_rgb, UFC);
        end
        cmp("t4_count", {underflow, underflow_count}, {1'b1, 16'd5});
        step(1, 1, 1, 16'($urandom()));
        after_edge();
        cmp("t4_clear", {underflow, underflow_count}, {1'b0, 16'd0});
        step(1, 0, 1, 16'($urandom()));
        after_edge();
        cmp("t4_clr_and_new", {underflow, underflow_count}, {1'b1, 16'd1});
        step(1, 1, 1, 16'($urandom()));

        // T5: disable at line 10, frame completes, idle, restart at origin.
        for (int i = 0; i < F && m_pos != 10 * HT; i++) rstep(100, 90);
        for (int i = 0; i < 2 * F && m_on; i++) rstep(0, 90);
        for (int i = 0; i < 20; i++) begin
            rstep(0, 90);
            after_edge();
            cmp("t5_idle", {lcd_hsync, lcd_vsync, lcd_de, asi_in0_ready}, {!POL, !POL, 2'b00});
        end
        step(1, 1, 0, 16'($urandom()));
        step(1, 1, 0, 16'h07E0);
        after_edge();
        cmp("t5_restart", {lcd_de, lcd_rgb}, {1'b1, 24'h00FF00});
        for (int i = 0; i < 400; i++) rstep(98, 90);

        // T6: starve until the counter must have saturated.
        m_uf_raw = 0;
        for (int i = 0; i < 90000 && m_uf_raw < 65540; i++) step(1, 0, 0, 16'($urandom()));
        after_edge();
        cmp("t6_saturate", {underflow, underflow_count}, {1'b1, 16'hFFFF});

        cmp("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
